// File: rtl/exec_unit_seq.sv
// exec_unit_seq
// Sequential execute stage: 32-entry GPR file, SGPR high-product register and
// registered flags behind a valid/ready instruction handshake. Single-cycle ALU
// ops go through EXEC; mul runs an iterative shift-add engine in MUL.
//
// Ports
//   clk            rising-edge clock
//   sys_rst_n      synchronous active-low reset
//   instr_valid_i  instr_i is valid
//   instr_ready_o  unit idle and able to accept
//   instr_i        instruction word {op, rdst, rsrc1, imm_mode, rsrc2/imm}
//   done_o         one-cycle pulse: instruction retired
//   illegal_o      qualifies done_o: unknown opcode, nothing written
//   flags_o        {sign, zero, overflow, carry}
//   sgpr_o         SGPR contents (upper half of last mul product)
//   dbg_addr_i     debug read address
//   dbg_data_o     GPR[dbg_addr_i], combinational
module exec_unit_seq #(
    parameter int DATA_W = 16,
    parameter int NREG   = 32
) (
    input  logic              clk,
    input  logic              sys_rst_n,
    input  logic              instr_valid_i,
    output logic              instr_ready_o,
    input  logic [31:0]       instr_i,
    output logic              done_o,
    output logic              illegal_o,
    output logic [3:0]        flags_o,
    output logic [DATA_W-1:0] sgpr_o,
    input  logic [4:0]        dbg_addr_i,
    output logic [DATA_W-1:0] dbg_data_o
);

    localparam int CNT_W = $clog2(DATA_W);

    localparam logic [4:0] OP_MOVSGPR = 5'b00000;
    localparam logic [4:0] OP_MOV     = 5'b00001;
    localparam logic [4:0] OP_ADD     = 5'b00010;
    localparam logic [4:0] OP_SUB     = 5'b00011;
    localparam logic [4:0] OP_MUL     = 5'b00100;
    localparam logic [4:0] OP_OR      = 5'b00101;
    localparam logic [4:0] OP_AND     = 5'b00110;
    localparam logic [4:0] OP_XOR     = 5'b00111;
    localparam logic [4:0] OP_XNOR    = 5'b01000;
    localparam logic [4:0] OP_NAND    = 5'b01001;
    localparam logic [4:0] OP_NOR     = 5'b01010;
    localparam logic [4:0] OP_NOT     = 5'b01011;

    typedef enum logic [1:0] {IDLE, EXEC, MUL} state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   gpr_q [NREG];
    logic [DATA_W-1:0]   sgpr_q;
    logic [3:0]          flags_q;
    logic                done_q, illegal_q;
    logic [4:0]          op_q, rdst_q;
    logic                imm_mode_q;
    logic [DATA_W-1:0]   a_q, b_q, sgpr_lat_q;
    logic [2*DATA_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q;

    logic [DATA_W-1:0]   imm_zext, opnd_a, opnd_b;
    logic                accept, mul_last, op_illegal;
    logic [DATA_W:0]     mul_sum, sum_w, diff_w;
    logic [DATA_W-1:0]   alu_res;
    logic                alu_c, alu_v;
    logic                retire, gpr_we, sgpr_we, flags_we;
    logic [DATA_W-1:0]   wr_data;
    logic [3:0]          flags_d;

    // Operands are read at accept time so rdst may alias a source register.
    assign imm_zext   = DATA_W'(instr_i[15:0]);
    assign opnd_a     = gpr_q[instr_i[21:17]];
    assign opnd_b     = instr_i[16] ? imm_zext : gpr_q[instr_i[15:11]];
    assign accept     = instr_valid_i && instr_ready_o;
    assign mul_last   = (cnt_q == CNT_W'(DATA_W - 1));
    assign op_illegal = (op_q > OP_NOT);

    // One shift-add step: the upper half accumulates the multiplicand while
    // the lower half starts as the multiplier and is consumed LSB first.
    always_comb begin
        mul_sum = {1'b0, acc_q[2*DATA_W-1:DATA_W]}
                + (acc_q[0] ? {1'b0, a_q} : {(DATA_W+1){1'b0}});
        acc_d   = {mul_sum, acc_q[DATA_W-1:1]};
    end

    // Single-cycle ALU; the extra top bit of diff_w is the unsigned borrow.
    always_comb begin
        sum_w   = {1'b0, a_q} + {1'b0, b_q};
        diff_w  = {1'b0, a_q} - {1'b0, b_q};
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op_q)
            OP_MOVSGPR: alu_res = sgpr_lat_q;
            OP_MOV:     alu_res = imm_mode_q ? b_q : a_q;
            OP_ADD: begin
                alu_res = sum_w[DATA_W-1:0];
                alu_c   = sum_w[DATA_W];
                alu_v   = (a_q[DATA_W-1] == b_q[DATA_W-1]) &&
                          (alu_res[DATA_W-1] != a_q[DATA_W-1]);
            end
            OP_SUB: begin
                alu_res = diff_w[DATA_W-1:0];
                alu_c   = diff_w[DATA_W];
                alu_v   = (a_q[DATA_W-1] != b_q[DATA_W-1]) &&
                          (alu_res[DATA_W-1] != a_q[DATA_W-1]);
            end
            OP_OR:   alu_res = a_q | b_q;
            OP_AND:  alu_res = a_q & b_q;
            OP_XOR:  alu_res = a_q ^ b_q;
            OP_XNOR: alu_res = ~(a_q ^ b_q);
            OP_NAND: alu_res = ~(a_q & b_q);
            OP_NOR:  alu_res = ~(a_q | b_q);
            OP_NOT:  alu_res = imm_mode_q ? ~b_q : ~a_q;
            default: alu_res = '0;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = (instr_i[31:27] == OP_MUL) ? MUL : EXEC;
            EXEC:    state_d = IDLE;
            MUL:     if (mul_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: handshake and write enables for the retire edge.
    always_comb begin
        instr_ready_o = (state_q == IDLE) && sys_rst_n;
        retire        = 1'b0;
        gpr_we        = 1'b0;
        sgpr_we       = 1'b0;
        flags_we      = 1'b0;
        case (state_q)
            EXEC: begin
                retire   = 1'b1;
                gpr_we   = !op_illegal;
                flags_we = !op_illegal;
            end
            MUL: begin
                if (mul_last) begin
                    retire   = 1'b1;
                    gpr_we   = 1'b1;
                    sgpr_we  = 1'b1;
                    flags_we = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Writeback data; mul flags come from the full double-width product.
    always_comb begin
        if (state_q == MUL) begin
            wr_data = acc_d[DATA_W-1:0];
            flags_d = {acc_d[2*DATA_W-1], (acc_d == '0), 2'b00};
        end else begin
            wr_data = alu_res;
            flags_d = {alu_res[DATA_W-1], (alu_res == '0), alu_v, alu_c};
        end
    end

    // Datapath registers, register file and status outputs.
    always_ff @(posedge clk) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < NREG; i++) gpr_q[i] <= '0;
            sgpr_q     <= '0;
            flags_q    <= '0;
            done_q     <= 1'b0;
            illegal_q  <= 1'b0;
            op_q       <= '0;
            rdst_q     <= '0;
            imm_mode_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            sgpr_lat_q <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
        end else begin
            if (accept) begin
                op_q       <= instr_i[31:27];
                rdst_q     <= instr_i[26:22];
                imm_mode_q <= instr_i[16];
                a_q        <= opnd_a;
                b_q        <= opnd_b;
                sgpr_lat_q <= sgpr_q;
                acc_q      <= {{DATA_W{1'b0}}, opnd_b};
                cnt_q      <= '0;
            end
            if (state_q == MUL) begin
                acc_q <= acc_d;
                cnt_q <= cnt_q + 1'b1;
            end
            if (gpr_we)   gpr_q[rdst_q] <= wr_data;
            if (sgpr_we)  sgpr_q <= acc_d[2*DATA_W-1:DATA_W];
            if (flags_we) flags_q <= flags_d;
            done_q    <= retire;
            illegal_q <= retire && op_illegal;
        end
    end

    assign done_o     = done_q;
    assign illegal_o  = illegal_q;
    assign flags_o    = flags_q;
    assign sgpr_o     = sgpr_q;
    assign dbg_data_o = gpr_q[dbg_addr_i];

endmodule

// File: tb/tb_exec_unit_seq.sv
// tb_exec_unit_seq
// Drives a 16-bit and a 32-bit exec_unit_seq from one directed sequence.
// Each issued instruction is run through a small architectural model that
// pushes the expected retire state onto a queue; the entry is popped and
// compared when the selected unit pulses done_o.
module tb_exec_unit_seq;

    localparam logic [4:0] OP_MOVSGPR = 5'd0;
    localparam logic [4:0] OP_MOV     = 5'd1;
    localparam logic [4:0] OP_ADD     = 5'd2;
    localparam logic [4:0] OP_SUB     = 5'd3;
    localparam logic [4:0] OP_MUL     = 5'd4;
    localparam logic [4:0] OP_OR      = 5'd5;
    localparam logic [4:0] OP_AND     = 5'd6;
    localparam logic [4:0] OP_XOR     = 5'd7;
    localparam logic [4:0] OP_XNOR    = 5'd8;
    localparam logic [4:0] OP_NAND    = 5'd9;
    localparam logic [4:0] OP_NOR     = 5'd10;
    localparam logic [4:0] OP_NOT     = 5'd11;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] val;
        logic [3:0]  flg;
        logic [31:0] sgpr;
        logic        ill;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        valid16 = 1'b0;
    logic        valid32 = 1'b0;
    logic [31:0] instr = '0;
    logic [4:0]  dbgAddr = '0;

    logic        ready16, done16, ill16;
    logic [3:0]  flags16;
    logic [15:0] sgpr16, dbg16;
    logic        ready32, done32, ill32;
    logic [3:0]  flags32;
    logic [31:0] sgpr32, dbg32;

    logic        cReady, cDone, cIll;
    logic [3:0]  cFlags;
    logic [31:0] cSgpr, cDbg;

    int          curW = 16;
    int          assertCount = 0;
    int          failCount = 0;

    logic [31:0] shReg [32];
    logic [31:0] shSgpr;
    logic [3:0]  shFlags;
    exp_t        sbQ [$];

    always #5 clk = ~clk;

    exec_unit_seq #(.DATA_W(16)) dut16 (
        .clk           (clk),
        .sys_rst_n     (rstN),
        .instr_valid_i (valid16),
        .instr_ready_o (ready16),
        .instr_i       (instr),
        .done_o        (done16),
        .illegal_o     (ill16),
        .flags_o       (flags16),
        .sgpr_o        (sgpr16),
        .dbg_addr_i    (dbgAddr),
        .dbg_data_o    (dbg16)
    );

    exec_unit_seq #(.DATA_W(32)) dut32 (
        .clk           (clk),
        .sys_rst_n     (rstN),
        .instr_valid_i (valid32),
        .instr_ready_o (ready32),
        .instr_i       (instr),
        .done_o        (done32),
        .illegal_o     (ill32),
        .flags_o       (flags32),
        .sgpr_o        (sgpr32),
        .dbg_addr_i    (dbgAddr),
        .dbg_data_o    (dbg32)
    );

    // Route the outputs of whichever width is under test.
    always_comb begin
        if (curW == 32) begin
            cReady = ready32; cDone = done32; cIll = ill32;
            cFlags = flags32; cSgpr = sgpr32; cDbg = dbg32;
        end else begin
            cReady = ready16; cDone = done16; cIll = ill16;
            cFlags = flags16; cSgpr = {16'h0, sgpr16}; cDbg = {16'h0, dbg16};
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish (observed timeout, expected completion)");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] encI(logic [4:0] op, logic [4:0] rd, logic [4:0] rs1, logic [15:0] imm);
        return {op, rd, rs1, 1'b1, imm};
    endfunction

    function automatic logic [31:0] encR(logic [4:0] op, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
        return {op, rd, rs1, 1'b0, rs2, 11'd0};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s (W=%0d): observed %h, expected %h", tag, curW, obs, exp);
        end
    endtask

    task automatic setValid(input logic v);
        if (curW == 32) valid32 = v;
        else valid16 = v;
    endtask

    task automatic readReg(input logic [4:0] a, output logic [31:0] v);
        dbgAddr = a;
        #1;
        v = cDbg;
    endtask

    // Architectural model: computes the retire state and updates the shadows.
    task automatic modelStep(input logic [31:0] ins, output exp_t e);
        logic [4:0]  op, rd, rs1, rs2;
        logic        im, c, v, s, z;
        logic [31:0] a, b, r, mask, hi;
        logic [63:0] full;
        int          msb;
        op = ins[31:27]; rd = ins[26:22]; rs1 = ins[21:17]; im = ins[16]; rs2 = ins[15:11];
        mask = (curW == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        msb  = curW - 1;
        a    = shReg[rs1];
        b    = im ? {16'h0, ins[15:0]} : shReg[rs2];
        r = '0; hi = shSgpr; c = 1'b0; v = 1'b0; full = '0;
        case (op)
            OP_MOVSGPR: r = shSgpr;
            OP_MOV:     r = im ? b : a;
            OP_ADD: begin
                full = {32'h0, a} + {32'h0, b};
                r = full[31:0] & mask;
                c = full[curW];
                v = (a[msb] == b[msb]) && (r[msb] != a[msb]);
            end
            OP_SUB: begin
                r = (a - b) & mask;
                c = (a < b);
                v = (a[msb] != b[msb]) && (r[msb] != a[msb]);
            end
            OP_MUL: begin
                full = {32'h0, a} * {32'h0, b};
                r  = full[31:0] & mask;
                hi = (curW == 32) ? full[63:32] : {16'h0, full[31:16]};
            end
            OP_OR:   r = (a | b) & mask;
            OP_AND:  r = (a & b) & mask;
            OP_XOR:  r = (a ^ b) & mask;
            OP_XNOR: r = ~(a ^ b) & mask;
            OP_NAND: r = ~(a & b) & mask;
            OP_NOR:  r = ~(a | b) & mask;
            OP_NOT:  r = (im ? ~b : ~a) & mask;
            default: r = '0;
        endcase
        if (op == OP_MUL) begin
            s = full[2*curW-1];
            z = (full == 64'h0);
        end else begin
            s = r[msb];
            z = (r == 32'h0);
        end
        e.rd  = rd;
        e.ill = (op > OP_NOT);
        e.lat = (op == OP_MUL) ? curW : 1;
        if (!e.ill) begin
            shReg[rd] = r;
            shSgpr    = hi;
            shFlags   = {s, z, v, c};
        end
        e.val  = shReg[rd];
        e.sgpr = shSgpr;
        e.flg  = shFlags;
    endtask

    task automatic waitReady();
        int n;
        n = 0;
        while (!cReady && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("ready wait in budget", (n < 100), 1);
    endtask

    // Called just after the accept edge; counts edges until done_o, then
    // pops the oldest expectation and compares the retire state.
    task automatic waitRetire();
        exp_t        e;
        int          edges;
        logic        seen, readyLow;
        logic [31:0] v;
        edges = 0; seen = 1'b0; readyLow = 1'b1;
        while (!seen && edges < 100) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (cDone) seen = 1'b1;
            else if (cReady) readyLow = 1'b0;
        end
        checkOutput("done seen", seen, 1);
        e = sbQ.pop_front();
        checkOutput("latency", edges, e.lat);
        checkOutput("ready low while busy", readyLow, 1);
        checkOutput("ready at retire", cReady, 1);
        checkOutput("illegal", cIll, e.ill);
        checkOutput("flags", cFlags, e.flg);
        checkOutput("sgpr", cSgpr, e.sgpr);
        readReg(e.rd, v);
        checkOutput("gpr rdst", v, e.val);
    endtask

    task automatic applyStimulus(input logic [31:0] ins);
        exp_t e;
        modelStep(ins, e);
        sbQ.push_back(e);
        waitReady();
        instr = ins;
        setValid(1'b1);
        @(posedge clk);
        #1;
        setValid(1'b0);
        waitRetire();
    endtask

    task automatic checkCleared(input string tag);
        int          nonZero;
        logic [31:0] v;
        checkOutput({tag, " ready"}, cReady, 1);
        checkOutput({tag, " flags"}, cFlags, 0);
        checkOutput({tag, " sgpr"}, cSgpr, 0);
        checkOutput({tag, " done"}, cDone, 0);
        checkOutput({tag, " illegal"}, cIll, 0);
        nonZero = 0;
        for (int i = 0; i < 32; i++) begin
            readReg(5'(i), v);
            if (v !== 32'h0) nonZero++;
        end
        checkOutput({tag, " nonzero gprs"}, nonZero, 0);
        for (int i = 0; i < 32; i++) shReg[i] = '0;
        shSgpr = '0;
        shFlags = '0;
        sbQ.delete();
    endtask

    task automatic doReset();
        rstN = 1'b0; valid16 = 1'b0; valid32 = 1'b0; instr = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("ready in reset", cReady, 0);
        @(negedge clk);
        rstN = 1'b1;
        #1;
        checkCleared("after reset");
    endtask

    // Second instruction presented with valid held during a mul.
    task automatic holdValidTest();
        exp_t        e1, e2;
        logic [31:0] i1, i2;
        i1 = encI(OP_MUL, 5'd5, 5'd4, 16'h0003);
        i2 = encI(OP_ADD, 5'd8, 5'd5, 16'h0001);
        modelStep(i1, e1); sbQ.push_back(e1);
        modelStep(i2, e2); sbQ.push_back(e2);
        waitReady();
        instr = i1;
        setValid(1'b1);
        @(posedge clk);
        #1;
        instr = i2;
        waitRetire();
        @(posedge clk);
        #1;
        setValid(1'b0);
        waitRetire();
    endtask

    // Reset while the mul counter sits at 5.
    task automatic resetMidMul();
        int pulses;
        waitReady();
        instr = encI(OP_MUL, 5'd9, 5'd4, 16'h0003);
        setValid(1'b1);
        @(posedge clk);
        #1;
        setValid(1'b0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rstN = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("mid-mul ready in reset", cReady, 0);
        checkOutput("mid-mul done in reset", cDone, 0);
        @(negedge clk);
        rstN = 1'b1;
        #1;
        checkCleared("mid-mul reset");
        pulses = 0;
        repeat (curW + 4) begin
            @(negedge clk);
            if (cDone) pulses++;
        end
        checkOutput("mid-mul no late retire", pulses, 0);
    endtask

    task automatic runSuite(input int w);
        logic [31:0] v, ones;
        curW = w;
        ones = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        $display("[TB] running DATA_W=%0d", w);
        doReset();

        applyStimulus(encI(OP_MOV, 5'd1, 5'd0, 16'h0005));
        applyStimulus(encI(OP_ADD, 5'd2, 5'd1, 16'h0003));
        readReg(5'd2, v);
        checkOutput("add 5+3", v, 32'h8);
        checkOutput("add 5+3 flags", cFlags, 4'b0000);

        if (w == 16) begin
            applyStimulus(encI(OP_MOV, 5'd1, 5'd0, 16'h7FFF));
        end else begin
            applyStimulus(encI(OP_MOV, 5'd10, 5'd0, 16'hFFFF));
            applyStimulus(encI(OP_MUL, 5'd11, 5'd10, 16'h8000));
            applyStimulus(encI(OP_OR, 5'd1, 5'd11, 16'h7FFF));
        end
        applyStimulus(encI(OP_ADD, 5'd3, 5'd1, 16'h0001));
        readReg(5'd3, v);
        checkOutput("add maxpos+1", v, (w == 32) ? 32'h8000_0000 : 32'h0000_8000);
        checkOutput("add maxpos+1 flags", cFlags, 4'b1010);
        applyStimulus(encI(OP_NOT, 5'd1, 5'd0, 16'h0000));
        applyStimulus(encI(OP_ADD, 5'd3, 5'd1, 16'h0001));
        readReg(5'd3, v);
        checkOutput("add ones+1", v, 32'h0);
        checkOutput("add ones+1 flags", cFlags, 4'b0101);

        applyStimulus(encI(OP_MOV, 5'd4, 5'd0, 16'h1234));
        applyStimulus(encI(OP_MUL, 5'd5, 5'd4, 16'h0100));
        readReg(5'd5, v);
        checkOutput("mul low", v, (w == 32) ? 32'h0012_3400 : 32'h0000_3400);
        checkOutput("mul sgpr", cSgpr, (w == 32) ? 32'h0 : 32'h12);
        applyStimulus(encI(OP_MOVSGPR, 5'd6, 5'd0, 16'h0000));
        readReg(5'd6, v);
        checkOutput("movsgpr", v, (w == 32) ? 32'h0 : 32'h12);

        applyStimulus(encI(OP_SUB, 5'd7, 5'd0, 16'h0001));
        readReg(5'd7, v);
        checkOutput("sub 0-1", v, ones);
        checkOutput("sub 0-1 flags", cFlags, 4'b1001);

        applyStimulus(encR(OP_XOR, 5'd8, 5'd4, 5'd5));
        applyStimulus(encR(OP_AND, 5'd8, 5'd4, 5'd7));
        applyStimulus(encR(OP_OR, 5'd9, 5'd5, 5'd4));
        applyStimulus(encR(OP_XNOR, 5'd9, 5'd9, 5'd4));
        applyStimulus(encR(OP_NAND, 5'd10, 5'd4, 5'd7));
        applyStimulus(encR(OP_NOR, 5'd10, 5'd4, 5'd0));
        applyStimulus(encR(OP_NOT, 5'd11, 5'd4, 5'd0));
        applyStimulus(encR(OP_MOV, 5'd12, 5'd4, 5'd0));
        applyStimulus(encR(OP_SUB, 5'd12, 5'd12, 5'd5));
        applyStimulus(encR(OP_ADD, 5'd13, 5'd7, 5'd7));
        applyStimulus(encR(OP_MUL, 5'd13, 5'd7, 5'd7));
        applyStimulus(encR(OP_MUL, 5'd14, 5'd0, 5'd4));

        applyStimulus(encI(5'b11111, 5'd2, 5'd1, 16'hABCD));

        holdValidTest();
        resetMidMul();
    endtask

    initial begin
        runSuite(16);
        runSuite(32);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
